// File: rtl/tick_capture_fifo.sv
// Tick-qualified capture FIFO with first-word fall-through output,
// occupancy count and a sticky overflow flag for dropped captures.
module tick_capture_fifo #(
   parameter int N_BITS = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clk_enable,
   input  logic                       i_tick,
   input  logic [N_BITS-1:0]          i_data,
   input  logic                       i_ready,
   input  logic                       i_clear_ovf,
   output logic [N_BITS-1:0]          o_data,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [N_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic empty;
   logic full;
   logic push_req;
   logic pop;
   logic push;
   logic drop;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   always_comb begin
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      push_req = clk_enable && i_tick;
      pop      = !empty && i_ready;
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide what
   // is visible, so stale words can never reach o_data.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= i_data;
   end

   // A drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           o_overflow <= 1'b0;
      else if (drop)        o_overflow <= 1'b1;
      else if (i_clear_ovf) o_overflow <= 1'b0;
   end

   always_comb begin
      o_valid = !empty;
      o_level = wr_ptr - rd_ptr;
      o_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   end

endmodule
